// File: rtl/mest_pro_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mest_pro_seq_pkg
//   Shared types and constants for the MESTPro instruction sequencer.
//   - seq_state_e : sequencer FSM state encoding
//   - OPC/OPA/OPB : bit slices of the 24-bit instruction word
//                   {opcode[23:16], opA[15:8], opB[7:0]}
// ---------------------------------------------------------------------------
package mest_pro_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    WAIT_MEM  = 3'd2,
    EXEC      = 3'd3,
    WAIT_DONE = 3'd4,
    UPDATE    = 3'd5,
    STEP      = 3'd6,
    HALT      = 3'd7
  } seq_state_e;

  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 16;
  localparam int OPA_MSB = 15;
  localparam int OPA_LSB = 8;
  localparam int OPB_MSB = 7;
  localparam int OPB_LSB = 0;

endpackage

// File: rtl/mest_pro_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mest_pro_seq_ctrl_if
//   Bus bundle between the sequencer and its neighbours.
//   Program memory side : o_imem_addr, o_imem_rd  -> memory
//                         i_imem_data, i_imem_valid <- memory
//   Execute unit side   : o_execute, o_op_code, o_operand1, o_operand2 -> exec
//                         i_exec_done, i_jump, i_return_pc, i_end_of_code <- exec
//   modport master : the sequencer
//   modport slave  : memory + execute unit (or a testbench model of them)
// ---------------------------------------------------------------------------
interface mest_pro_seq_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
);
  logic [PC_W-1:0]    o_imem_addr;
  logic               o_imem_rd;
  logic [INSTR_W-1:0] i_imem_data;
  logic               i_imem_valid;

  logic               o_execute;
  logic [7:0]         o_op_code;
  logic [7:0]         o_operand1;
  logic [7:0]         o_operand2;
  logic               i_exec_done;
  logic               i_jump;
  logic               i_return_pc;
  logic               i_end_of_code;

  modport master (
    output o_imem_addr, o_imem_rd, o_execute, o_op_code, o_operand1, o_operand2,
    input  i_imem_data, i_imem_valid, i_exec_done, i_jump, i_return_pc, i_end_of_code
  );

  modport slave (
    input  o_imem_addr, o_imem_rd, o_execute, o_op_code, o_operand1, o_operand2,
    output i_imem_data, i_imem_valid, i_exec_done, i_jump, i_return_pc, i_end_of_code
  );
endinterface

// File: rtl/mest_pro_seq_ctrl_ret_stack.sv
// ---------------------------------------------------------------------------
// mest_pro_ret_stack
//   Small LIFO of return addresses for JMP (push) / RET (pop).
//   Ports:
//     clk, i_reset_n : clock, asynchronous active-low reset (clears contents)
//     i_clear        : synchronous pointer clear (restart of the program)
//     i_push, i_data : push i_data when not full (ignored when full)
//     i_pop          : drop top entry when not empty (ignored when empty)
//     o_top          : current top entry (valid when !o_empty)
//     o_full,o_empty : occupancy flags
//   The pointer carries one extra bit so DEPTH entries can be told apart
//   from zero entries.
// ---------------------------------------------------------------------------
module mest_pro_ret_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   SP_ONE  = 1;
  localparam logic [PTR_W-1:0] IDX_ONE = 1;

  logic [PTR_W:0]   sp_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;

  assign wr_idx  = sp_reg[PTR_W-1:0];
  assign top_idx = sp_reg[PTR_W-1:0] - IDX_ONE;
  assign o_full  = sp_reg[PTR_W];
  assign o_empty = (sp_reg == '0);
  assign o_top   = mem_reg[top_idx];

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sp_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (i_clear) begin
      sp_reg <= '0;
    end else if (i_push && !o_full) begin
      mem_reg[wr_idx] <= i_data;
      sp_reg          <= sp_reg + SP_ONE;
    end else if (i_pop && !o_empty) begin
      sp_reg <= sp_reg - SP_ONE;
    end
  end

endmodule

// File: rtl/mest_pro_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mest_pro_seq_ctrl
//   Instruction sequencer for the MESTPro core. Fetches {opcode,opA,opB}
//   from program memory, strobes the execute unit, waits for completion and
//   updates the PC from the jump / return / end-of-code flags. JMP pushes the
//   return address (PC+1) onto a small stack, RET pops it.
//
//   Optional feature macro: SEQ_SINGLE_STEP_EN
//     defined   -> extra input i_step; after each instruction the FSM parks
//                  in STEP (still busy) until i_step=1.
//     undefined -> UPDATE goes straight to FETCH.
//
//   Ports:
//     clk, i_reset_n : clock, asynchronous active-low reset
//     i_start        : start/restart at PC 0 (only honoured in IDLE/HALT)
//     i_step         : single-step advance (SEQ_SINGLE_STEP_EN only)
//     bus            : memory + execute-unit bundle (master modport)
//     o_pc           : current PC
//     o_busy         : 1 outside IDLE/HALT
//     o_halted       : 1 in HALT
//     o_stack_err    : sticky return-stack overflow/underflow
//   All outputs are registered.
// ---------------------------------------------------------------------------
module mest_pro_seq_ctrl
  import mest_pro_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 24,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            i_reset_n,
  input  logic            i_start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic            i_step,
`endif
  mest_pro_seq_ctrl_if.master bus,
  output logic [PC_W-1:0] o_pc,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_stack_err
);
  localparam logic [PC_W-1:0] PC_ONE = 1;

  seq_state_e         state_reg;
  logic [PC_W-1:0]    pc_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic               imem_rd_reg;
  logic               execute_reg;
  logic               busy_reg;
  logic               halted_reg;
  logic               err_reg;
  // Flags captured in the exec-done cycle, acted on in UPDATE.
  logic               eoc_reg;
  logic               jump_reg;
  logic               ret_reg;

  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    stk_top;
  logic               stk_full;
  logic               stk_empty;
  logic               stk_push;
  logic               stk_pop;
  logic               stk_clear;

  assign pc_plus1 = pc_reg + PC_ONE;

  // Push and pop are mutually exclusive by the UPDATE priority order.
  assign stk_push  = (state_reg == UPDATE) && !eoc_reg && jump_reg && !stk_full;
  assign stk_pop   = (state_reg == UPDATE) && !eoc_reg && !jump_reg && ret_reg && !stk_empty;
  assign stk_clear = ((state_reg == IDLE) || (state_reg == HALT)) && i_start;

  mest_pro_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_W)
  ) u_stack (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_clear   (stk_clear),
    .i_push    (stk_push),
    .i_pop     (stk_pop),
    .i_data    (pc_plus1),
    .o_top     (stk_top),
    .o_full    (stk_full),
    .o_empty   (stk_empty)
  );

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= IDLE;
      pc_reg      <= '0;
      instr_reg   <= '0;
      imem_rd_reg <= 1'b0;
      execute_reg <= 1'b0;
      busy_reg    <= 1'b0;
      halted_reg  <= 1'b0;
      err_reg     <= 1'b0;
      eoc_reg     <= 1'b0;
      jump_reg    <= 1'b0;
      ret_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, HALT: begin
          if (i_start) begin
            pc_reg      <= '0;
            err_reg     <= 1'b0;
            imem_rd_reg <= 1'b1;
            busy_reg    <= 1'b1;
            halted_reg  <= 1'b0;
            state_reg   <= FETCH;
          end
        end
        // Read request is high for exactly the FETCH cycle.
        FETCH: begin
          imem_rd_reg <= 1'b0;
          state_reg   <= WAIT_MEM;
        end
        WAIT_MEM: begin
          if (bus.i_imem_valid) begin
            instr_reg   <= bus.i_imem_data;
            execute_reg <= 1'b1;
            state_reg   <= EXEC;
          end
        end
        EXEC: begin
          execute_reg <= 1'b0;
          state_reg   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.i_exec_done) begin
            eoc_reg   <= bus.i_end_of_code;
            jump_reg  <= bus.i_jump;
            ret_reg   <= bus.i_return_pc;
            state_reg <= UPDATE;
          end
        end
        UPDATE: begin
          if (eoc_reg) begin
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
            state_reg  <= HALT;
          end else if ((jump_reg && stk_full) || (!jump_reg && ret_reg && stk_empty)) begin
            // Stack overflow on JMP or underflow on RET: PC stays on the
            // offending instruction.
            err_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            halted_reg <= 1'b1;
            state_reg  <= HALT;
          end else begin
            if (jump_reg)     pc_reg <= PC_W'(instr_reg[OPA_MSB:OPA_LSB]);
            else if (ret_reg) pc_reg <= stk_top;
            else              pc_reg <= pc_plus1;
`ifdef SEQ_SINGLE_STEP_EN
            state_reg <= STEP;
`else
            imem_rd_reg <= 1'b1;
            state_reg   <= FETCH;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        STEP: begin
          if (i_step) begin
            imem_rd_reg <= 1'b1;
            state_reg   <= FETCH;
          end
        end
`endif
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_imem_addr = pc_reg;
  assign bus.o_imem_rd   = imem_rd_reg;
  assign bus.o_execute   = execute_reg;
  assign bus.o_op_code   = instr_reg[OPC_MSB:OPC_LSB];
  assign bus.o_operand1  = instr_reg[OPA_MSB:OPA_LSB];
  assign bus.o_operand2  = instr_reg[OPB_MSB:OPB_LSB];
  assign o_pc            = pc_reg;
  assign o_busy          = busy_reg;
  assign o_halted        = halted_reg;
  assign o_stack_err     = err_reg;

endmodule

// File: tb/tb_mest_pro_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mest_pro_seq_ctrl
//   Directed bench for the MESTPro sequencer. Program memory and execute
//   unit are modelled on the falling edge; expected values are hand-derived.
//   Opcodes used by the execute model: ADD=01, JMP=02, RET=03, HALT=FF.
// ---------------------------------------------------------------------------
module tb_mest_pro_seq_ctrl;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_JMP  = 8'h02;
  localparam logic [7:0] OP_RET  = 8'h03;
  localparam logic [7:0] OP_HALT = 8'hFF;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_start;
  logic       i_step;
  logic [7:0] o_pc;
  logic       o_busy, o_halted, o_stack_err;

  mest_pro_seq_ctrl_if #(.PC_W(8), .INSTR_W(24)) bus ();

  mest_pro_seq_ctrl #(.PC_W(8), .INSTR_W(24), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_start     (i_start),
`ifdef SEQ_SINGLE_STEP_EN
    .i_step      (i_step),
`endif
    .bus         (bus),
    .o_pc        (o_pc),
    .o_busy      (o_busy),
    .o_halted    (o_halted),
    .o_stack_err (o_stack_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] imem [256];
  int mem_lat;
  int exec_hold;
  int fetch_q[$];
  int exec_pc_q[$];
  int gap_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic int fetch_at(input int i);
    return (i < fetch_q.size()) ? fetch_q[i] : -1;
  endfunction

  function automatic int exec_pc_at(input int i);
    return (i < exec_pc_q.size()) ? exec_pc_q[i] : -1;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 24'h0;
  endtask

  // Program memory: latency mem_lat cycles after the read request.
  int mem_cnt = 0;
  int mem_addr = 0;
  int rd_cyc = 0;
  always @(negedge clk) begin
    if (!i_reset_n) begin
      mem_cnt          = 0;
      bus.i_imem_valid = 1'b0;
      bus.i_imem_data  = 24'h0;
    end else begin
      bus.i_imem_valid = 1'b0;
      if (bus.o_imem_rd) begin
        fetch_q.push_back(int'(bus.o_imem_addr));
        mem_addr = int'(bus.o_imem_addr);
        mem_cnt  = mem_lat;
        rd_cyc   = cyc;
      end else if (mem_cnt != 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.i_imem_valid = 1'b1;
          bus.i_imem_data  = imem[mem_addr];
        end
      end
    end
  end

  // Execute unit: done one cycle after the strobe, flags decoded from opcode.
  int exec_pend = 0;
  always @(negedge clk) begin
    if (!i_reset_n) begin
      exec_pend = 0;
      bus.i_exec_done = 1'b0; bus.i_jump = 1'b0;
      bus.i_return_pc = 1'b0; bus.i_end_of_code = 1'b0;
    end else begin
      bus.i_exec_done = 1'b0; bus.i_jump = 1'b0;
      bus.i_return_pc = 1'b0; bus.i_end_of_code = 1'b0;
      if (exec_pend != 0 && exec_hold == 0) begin
        bus.i_exec_done   = 1'b1;
        bus.i_jump        = (bus.o_op_code == OP_JMP);
        bus.i_return_pc   = (bus.o_op_code == OP_RET);
        bus.i_end_of_code = (bus.o_op_code == OP_HALT);
        exec_pend = 0;
      end
      if (bus.o_execute) begin
        exec_pc_q.push_back(int'(o_pc));
        gap_q.push_back(cyc - rd_cyc);
        exec_pend = 1;
      end
    end
  end

  task automatic start_prog();
    fetch_q.delete(); exec_pc_q.delete(); gap_q.delete();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!o_halted && n < 500) begin @(negedge clk); n++; end
    check({tag, "_halted"}, 32'(o_halted), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(bus.o_imem_addr), 0);
    check({tag, "_rd"},   32'(bus.o_imem_rd),   0);
    check({tag, "_exec"}, 32'(bus.o_execute),   0);
    check({tag, "_opc"},  32'(bus.o_op_code),   0);
    check({tag, "_opa"},  32'(bus.o_operand1),  0);
    check({tag, "_opb"},  32'(bus.o_operand2),  0);
    check({tag, "_pc"},   32'(o_pc),            0);
    check({tag, "_busy"}, 32'(o_busy),          0);
    check({tag, "_halt"}, 32'(o_halted),        0);
    check({tag, "_err"},  32'(o_stack_err),     0);
  endtask

  initial begin
    int n;
    i_reset_n = 1'b0; i_start = 1'b0; i_step = 1'b1;
    mem_lat = 1; exec_hold = 0;
    clear_imem();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_reset_n = 1'b1;
    @(negedge clk);
    $display("reset released");

    // 1: sequential ADD, ADD, HALT
    imem[0] = {OP_ADD, 8'h11, 8'h22};
    imem[1] = {OP_ADD, 8'h33, 8'h44};
    imem[2] = {OP_HALT, 8'h55, 8'h66};
    start_prog();
    wait_halt("seq");
    check("seq_nexec", 32'(exec_pc_q.size()), 3);
    check("seq_exec_pc0", 32'(exec_pc_at(0)), 0);
    check("seq_exec_pc1", 32'(exec_pc_at(1)), 1);
    check("seq_exec_pc2", 32'(exec_pc_at(2)), 2);
    check("seq_pc", 32'(o_pc), 2);
    check("seq_busy", 32'(o_busy), 0);
    check("seq_opa", 32'(bus.o_operand1), 32'h55);
    check("seq_gap", 32'(gap_q.size() > 0 ? gap_q[0] : -1), 2);
    $display("test1 sequential: pc=%0d execs=%0d", o_pc, exec_pc_q.size());

    // 2: call/return, then RET at 1 underflows (stack back to empty)
    clear_imem();
    imem[0]  = {OP_JMP, 8'h10, 8'h00};
    imem[16] = {OP_RET, 8'hA5, 8'h5A};
    imem[1]  = {OP_RET, 8'h3C, 8'hC3};
    start_prog();
    wait_halt("call");
    check("call_nfetch", 32'(fetch_q.size()), 3);
    check("call_f0", 32'(fetch_at(0)), 0);
    check("call_f1", 32'(fetch_at(1)), 16);
    check("call_f2", 32'(fetch_at(2)), 1);
    check("call_sp0_err", 32'(o_stack_err), 1);
    check("call_pc", 32'(o_pc), 1);
    check("call_opc", 32'(bus.o_op_code), 32'(OP_RET));
    check("call_opb", 32'(bus.o_operand2), 32'hC3);
    $display("test2 call/return: fetches=%0d pc=%0d", fetch_q.size(), o_pc);

    // 3: five nested JMPs overflow a 4-deep stack
    clear_imem();
    imem[0]  = {OP_JMP, 8'd10, 8'h0};
    imem[10] = {OP_JMP, 8'd20, 8'h0};
    imem[20] = {OP_JMP, 8'd30, 8'h0};
    imem[30] = {OP_JMP, 8'd40, 8'h0};
    imem[40] = {OP_JMP, 8'd50, 8'h0};
    start_prog();
    check("ovf_err_cleared", 32'(o_stack_err), 0);
    wait_halt("ovf");
    check("ovf_err", 32'(o_stack_err), 1);
    check("ovf_pc", 32'(o_pc), 40);
    check("ovf_nfetch", 32'(fetch_q.size()), 5);
    $display("test3 overflow: pc=%0d err=%0d", o_pc, o_stack_err);

    // 4: underflow, then restart clears the error
    clear_imem();
    imem[0] = {OP_RET, 8'h0, 8'h0};
    start_prog();
    wait_halt("unf");
    check("unf_err", 32'(o_stack_err), 1);
    check("unf_pc", 32'(o_pc), 0);
    start_prog();
    check("unf_restart_err", 32'(o_stack_err), 0);
    check("unf_restart_rd", 32'(bus.o_imem_rd), 1);
    check("unf_restart_addr", 32'(bus.o_imem_addr), 0);
    check("unf_restart_busy", 32'(o_busy), 1);
    wait_halt("unf2");
    check("unf2_fetch", 32'(fetch_at(0)), 0);
    $display("test4 underflow: err=%0d", o_stack_err);

    // 5a: memory wait states
    clear_imem();
    imem[0] = {OP_ADD, 8'h0, 8'h0};
    imem[1] = {OP_HALT, 8'h0, 8'h0};
    mem_lat = 4;
    start_prog();
    wait_halt("wait");
    check("wait_nexec", 32'(exec_pc_q.size()), 2);
    check("wait_gap", 32'(gap_q.size() > 0 ? gap_q[0] : -1), 5);
    mem_lat = 1;
    $display("test5a wait states: execs=%0d", exec_pc_q.size());

    // 5b: PC wrap 255 -> 0
    clear_imem();
    imem[0]   = {OP_JMP, 8'hFF, 8'h0};
    imem[255] = {OP_ADD, 8'h0, 8'h0};
    start_prog();
    n = 0;
    while (fetch_q.size() < 2 && n < 200) begin @(negedge clk); n++; end
    imem[0] = {OP_HALT, 8'h0, 8'h0};
    wait_halt("wrap");
    check("wrap_f1", 32'(fetch_at(1)), 255);
    check("wrap_f2", 32'(fetch_at(2)), 0);
    check("wrap_pc", 32'(o_pc), 0);
    check("wrap_err", 32'(o_stack_err), 0);
    $display("test5b wrap: pc=%0d", o_pc);

    // 6: asynchronous reset while waiting for exec-done
    clear_imem();
    imem[0] = {OP_JMP, 8'h77, 8'h88};
    exec_hold = 1;
    start_prog();
    n = 0;
    while (exec_pc_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    check("rstmid_busy_before", 32'(o_busy), 1);
    check("rstmid_opa_before", 32'(bus.o_operand1), 32'h77);
    #1 i_reset_n = 1'b0;
    #1 check_all_zero("rstmid");
    exec_hold = 0;
    @(negedge clk); i_reset_n = 1'b1;
    $display("test6 reset in WAIT_DONE");

`ifdef SEQ_SINGLE_STEP_EN
    // 6b: one fetch per step pulse
    clear_imem();
    imem[0] = {OP_ADD, 8'h0, 8'h0};
    imem[1] = {OP_ADD, 8'h0, 8'h0};
    imem[2] = {OP_HALT, 8'h0, 8'h0};
    i_step = 1'b0;
    start_prog();
    repeat (20) @(negedge clk);
    check("step_nfetch1", 32'(fetch_q.size()), 1);
    check("step_busy", 32'(o_busy), 1);
    check("step_pc", 32'(o_pc), 1);
    i_step = 1'b1; @(negedge clk); i_step = 1'b0;
    repeat (20) @(negedge clk);
    check("step_nfetch2", 32'(fetch_q.size()), 2);
    i_step = 1'b1; @(negedge clk); i_step = 1'b0;
    wait_halt("step");
    check("step_nfetch3", 32'(fetch_q.size()), 3);
    $display("test6b single step: fetches=%0d", fetch_q.size());
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
